// File: rtl/adsr_envelope.sv
// Four-phase ADSR amplitude envelope. Each strobed sample is scaled by
// level / 2^LEVEL_BITS and registered onto final_sample.
module adsr_envelope #(
    parameter int WIDTH      = 16,
    parameter int LEVEL_BITS = 3,
    parameter int RATE_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  note_start,
    input  logic                  note_release,
    input  logic                  generate_next_sample,
    input  logic [WIDTH-1:0]      sample,
    input  logic [RATE_BITS-1:0]  attack_rate,
    input  logic [RATE_BITS-1:0]  decay_rate,
    input  logic [RATE_BITS-1:0]  release_rate,
    input  logic [LEVEL_BITS:0]   sustain_level,
    output logic [WIDTH-1:0]      final_sample,
    output logic [LEVEL_BITS:0]   envelope_level,
    output logic [2:0]            envelope_state
);

    localparam int PROD_W = WIDTH + LEVEL_BITS + 1;
    localparam logic [LEVEL_BITS:0]  FULL     = {1'b1, {LEVEL_BITS{1'b0}}};
    localparam logic [LEVEL_BITS:0]  LVL_ONE  = {{LEVEL_BITS{1'b0}}, 1'b1};
    localparam logic [RATE_BITS-1:0] RATE_ONE = {{(RATE_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t                  state_p0, next_state;
    logic [LEVEL_BITS:0]     level_p0, next_level;
    logic [RATE_BITS-1:0]    count_p0, next_count;
    logic [LEVEL_BITS:0]     sustain_clamped;
    logic signed [WIDTH-1:0] sample_p1;

    // Signed sample times unsigned level, floored shift back down to WIDTH.
    function automatic logic signed [WIDTH-1:0] scale(
        input logic signed [WIDTH-1:0] s,
        input logic [LEVEL_BITS:0]     lvl
    );
        logic signed [PROD_W-1:0] prod;
        logic signed [PROD_W-1:0] shifted;
        prod    = $signed({{(LEVEL_BITS+1){s[WIDTH-1]}}, s}) *
                  $signed({{WIDTH{1'b0}}, lvl});
        shifted = prod >>> LEVEL_BITS;
        return shifted[WIDTH-1:0];
    endfunction

    function automatic logic step_due(
        input logic                 strobe,
        input logic [RATE_BITS-1:0] cnt,
        input logic [RATE_BITS-1:0] rate
    );
        return strobe && (cnt == rate - RATE_ONE);
    endfunction

    assign sustain_clamped = (sustain_level > FULL) ? FULL : sustain_level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p0 <= IDLE;
            level_p0 <= '0;
            count_p0 <= '0;
        end else begin
            state_p0 <= next_state;
            level_p0 <= next_level;
            count_p0 <= next_count;
        end
    end

    always_comb begin
        next_state = state_p0;
        next_level = level_p0;
        next_count = count_p0;
        if (note_start) begin
            next_state = ATTACK;
            next_count = '0;
        end else if (note_release &&
                     (state_p0 == ATTACK || state_p0 == DECAY || state_p0 == SUSTAIN)) begin
            next_state = RELEASE;
        end else begin
            case (state_p0)
                IDLE: next_level = '0;
                ATTACK: begin
                    if (level_p0 >= FULL) begin
                        next_state = DECAY;
                    end else if (attack_rate == '0) begin
                        next_level = FULL;
                        next_state = DECAY;
                    end else if (step_due(generate_next_sample, count_p0, attack_rate)) begin
                        next_level = level_p0 + LVL_ONE;
                        next_count = '0;
                        if (level_p0 + LVL_ONE == FULL) next_state = DECAY;
                    end else if (generate_next_sample) begin
                        next_count = count_p0 + RATE_ONE;
                    end
                end
                DECAY: begin
                    if (level_p0 <= sustain_clamped) begin
                        next_state = SUSTAIN;
                    end else if (decay_rate == '0) begin
                        next_level = sustain_clamped;
                        next_state = SUSTAIN;
                    end else if (step_due(generate_next_sample, count_p0, decay_rate)) begin
                        next_level = level_p0 - LVL_ONE;
                        next_count = '0;
                        if (level_p0 - LVL_ONE == sustain_clamped) next_state = SUSTAIN;
                    end else if (generate_next_sample) begin
                        next_count = count_p0 + RATE_ONE;
                    end
                end
                SUSTAIN: next_level = level_p0;
                RELEASE: begin
                    if (level_p0 == '0) begin
                        next_state = IDLE;
                    end else if (release_rate == '0) begin
                        next_level = '0;
                        next_state = IDLE;
                    end else if (step_due(generate_next_sample, count_p0, release_rate)) begin
                        next_level = level_p0 - LVL_ONE;
                        next_count = '0;
                        if (level_p0 == LVL_ONE) next_state = IDLE;
                    end else if (generate_next_sample) begin
                        next_count = count_p0 + RATE_ONE;
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_level = '0;
                end
            endcase
        end
        // Every phase change restarts strobe counting from zero.
        if (next_state != state_p0) next_count = '0;
    end

    // Output stage: scale with the level held at the start of the strobe cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_p1 <= '0;
        end else if (generate_next_sample) begin
            sample_p1 <= scale($signed(sample), level_p0);
        end
    end

    always_comb begin
        envelope_state = state_p0;
        envelope_level = level_p0;
        final_sample   = sample_p1;
    end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Parametrised four-phase (attack/decay/sustain/release) amplitude envelope for the note player's sample path, succeeding the fixed 1/8-step decay-only dynamics block. It sits between the sample generator and the codec output and scales each signed sample by a stepped gain of `level / 2^LEVEL_BITS`. Phase rates and the sustain level are run-time inputs. Note start and note release are explicit pulses, so held notes and early releases are supported.

## Interface
- `WIDTH`, 16, signed sample width.
- `LEVEL_BITS`, 3, gain resolution; FULL = 2^LEVEL_BITS (8 by default).
- `RATE_BITS`, 8, width of the rate inputs.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `note_start` input 1: one-cycle pulse that starts or retriggers the envelope.
- `note_release` input 1: one-cycle pulse that ends the held portion of the note.
- `generate_next_sample` input 1: sample strobe, one cycle per output sample.
- `sample` input WIDTH: signed input sample, valid on strobe cycles.
- `attack_rate`, `decay_rate`, `release_rate` input RATE_BITS each: number of strobes per level step; 0 means an immediate jump.
- `sustain_level` input LEVEL_BITS+1: sustain gain. Values above FULL are clamped to FULL.
- `final_sample` output WIDTH: signed scaled sample, registered.
- `envelope_level` output LEVEL_BITS+1: current level, 0..FULL.
- `envelope_state` output 3: encoded as IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

## Operation
- Reset values:
  - state IDLE, `envelope_level` 0, step counter 0, `final_sample` 0.
- Step counter counts strobes within a phase.
  - On a strobe where counter == rate−1, the level steps by ±1 and the counter clears.
  - The counter also clears on every state change and on `note_start`.
- IDLE: level holds at 0. `note_release` is ignored.
- ATTACK: level +1 per step. On reaching FULL, go to DECAY.
- DECAY: level −1 per step. On reaching the clamped sustain level, go to SUSTAIN. If level ≤ sustain on entry, go to SUSTAIN on the next edge without changing level.
- SUSTAIN: level holds. The clamped `sustain_level` is tracked only at entry; later changes to it have no effect until the next DECAY.
- RELEASE: level −1 per step. On reaching 0, go to IDLE.
- Rate of 0 in a phase: on the next clock edge (no strobe needed), the level jumps to that phase's target and the state advances.
  - ATTACK target is FULL, DECAY target is sustain, RELEASE target is 0.
- `note_start` in any state: go to ATTACK. The level is kept (legato retrigger, no click).
- `note_release` in ATTACK, DECAY or SUSTAIN: go to RELEASE; the level is kept.
- `note_start` and `note_release` in the same cycle: start wins.
- Rates are sampled live on every step decision.
- Arithmetic:
  - Product = signed `sample` × unsigned level, giving WIDTH+LEVEL_BITS+1 bits.
  - Result = product arithmetically shifted right by LEVEL_BITS (floor toward −∞), truncated to WIDTH.
  - No overflow is possible, since level ≤ FULL.

## Timing
- On a strobe cycle, `final_sample` ← scale(`sample`, level as held at the start of that cycle). The new value is visible one clock after the strobe.
- A level update made on the same strobe affects the next strobe only.
- With no strobe, `final_sample` holds its last value.
- `envelope_level` and `envelope_state` are registered and change only on clock edges.
- After a `note_start` with `attack_rate`=0:
  - edge 1: state ATTACK;
  - edge 2: level FULL, state DECAY;
  - the first following strobe outputs the full-scale sample.
- A phase with rate R ≥ 1 spans exactly R strobes per level step.
- Asserting `reset` mid-note forces all outputs to their reset values immediately; operation resumes in IDLE after deassertion.

## Test plan
- **Reset and idle:** apply reset with strobes, `sample`=10400 → `final_sample`=0, level 0, state IDLE; `note_release` alone → still IDLE.
- **Decay-only envelope** (attack 0, decay 4, sustain 0, `sample`=10400):
  - strobes 1–4 output 10400, strobes 5–8 output 9100, then 7800, 6500, 5200, 3900, 2600, 1300;
  - strobe 33 onward outputs 0 and the state holds SUSTAIN at level 0.
- **Negative samples**, same setup with `sample`=−10400 → −10400, −9100, …, −1300, 0.
- **Full ADSR** (attack 2, decay 1, sustain 4, release 3, `sample`=8000):
  - attack output sequence 0,0,1000,1000,…;
  - level reaches 8, then decays to 4; output holds 4000 in SUSTAIN;
  - after `note_release`, the level falls by one every 3 strobes to 0, then IDLE.
- **Retrigger and collisions:**
  - `note_start` during RELEASE at level 3 → ATTACK from 3, not 0;
  - simultaneous `note_start` + `note_release` → ATTACK.
- **Boundaries:**
  - `sustain_level`=12 → clamped to 8 and SUSTAIN is entered immediately after the attack;
  - release rate 0 → IDLE, level 0 within 2 edges;
  - reset asserted mid-DECAY → outputs 0 without waiting for a clock edge.
